// File: rtl/cpu_exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_defs
// Shared definitions for the execution controller of the 8-bit
// four-register RISC core: controller state encodings (also shown on the
// board LEDs) and the length of the core-reset pulse.
// ---------------------------------------------------------------------------
package cpu_ctrl_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    HALTED = 3'd3,
    CLEAR  = 3'd4
  } ctrl_state_e;

  // Number of clocks the core reset is held while in CLEAR
  localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/cpu_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_exec_ctrl_if
// Groups the board buttons, the core status inputs and the controller
// outputs that drive the core.
//   slave  : the controller side (buttons/core status in, control out)
//   master : the board/core side (drives buttons/status, observes control)
// Signals:
//   btn_step_n, btn_run_n, btn_clr_n : raw active-low push-buttons
//   cpu_halted      : core has decoded HALT (level)
//   cpu_instr_done  : one-cycle pulse when the core re-enters FETCH
//   cpu_en          : core advances one cycle-state when high
//   cpu_rst         : synchronous reset to the core
//   ctrl_state[2:0] : registered controller state
//   instr_count[7:0]: retired-instruction count
// ---------------------------------------------------------------------------
interface cpu_exec_ctrl_if;

  logic       btn_step_n;
  logic       btn_run_n;
  logic       btn_clr_n;
  logic       cpu_halted;
  logic       cpu_instr_done;
  logic       cpu_en;
  logic       cpu_rst;
  logic [2:0] ctrl_state;
  logic [7:0] instr_count;

  modport master (
    output btn_step_n, btn_run_n, btn_clr_n, cpu_halted, cpu_instr_done,
    input  cpu_en, cpu_rst, ctrl_state, instr_count
  );

  modport slave (
    input  btn_step_n, btn_run_n, btn_clr_n, cpu_halted, cpu_instr_done,
    output cpu_en, cpu_rst, ctrl_state, instr_count
  );

endinterface

// File: rtl/cpu_exec_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Cleans one raw active-low push-button into a one-cycle press event.
// A 2-flop synchronizer feeds a stability counter; the accepted level only
// follows the synced input after it has differed from the accepted level
// for DEBOUNCE_CYCLES consecutive clocks. A press is the accepted level
// going 1->0 and is reported the cycle after acceptance.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (-> "released")
//   i_btn_n   : raw button, active-low
//   o_press   : one-cycle press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_levelPrev;
  logic [DB_W-1:0] r_cnt;

  // Any sample agreeing with the accepted level restarts the stability
  // window, so only an uninterrupted run of differing samples is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_level     <= 1'b1;
      r_levelPrev <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_sync1     <= i_btn_n;
      r_sync2     <= r_sync1;
      r_levelPrev <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_levelPrev & ~r_level;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_exec_ctrl
// Execution controller for the 8-bit RISC core. Debounces the step/run/clr
// buttons and sequences the core with cpu_en pulses, either free-running at
// one pulse per RUN_DIV clocks or one instruction per step press. Drives the
// core reset, counts retired instructions and stops on HALT.
// Ports:
//   CLK_12MHz : system clock
//   RST       : asynchronous active-high reset
//   bus       : cpu_exec_ctrl_if.slave (buttons, core status, core control)
// ---------------------------------------------------------------------------
module cpu_exec_ctrl
  import cpu_ctrl_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int DB_W            = 18,
  parameter int RUN_DIV         = 1200000,
  parameter int DIV_W           = 21
) (
  input  logic          CLK_12MHz,
  input  logic          RST,
  cpu_exec_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [1:0]       CLR_LAST = 2'(CLEAR_CYCLES - 1);

  logic             w_stepEv;
  logic             w_runEv;
  logic             w_clrEv;
  logic             w_cpuEn;
  logic             w_divWrap;
  ctrl_state_e      r_state;
  ctrl_state_e      w_nextState;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_instrCount;
  logic [1:0]       r_clrCnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_dbStep (
    .clk(CLK_12MHz), .rst(RST), .i_btn_n(bus.btn_step_n), .o_press(w_stepEv)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_dbRun (
    .clk(CLK_12MHz), .rst(RST), .i_btn_n(bus.btn_run_n), .o_press(w_runEv)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_dbClr (
    .clk(CLK_12MHz), .rst(RST), .i_btn_n(bus.btn_clr_n), .o_press(w_clrEv)
  );

  assign w_divWrap = (r_div == DIV_LAST);

  // State register
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next state and cpu_en. Priority is clr > halted > run > step. Any
  // state change suppresses cpu_en so the core never advances on the cycle
  // the controller leaves RUN or STEP.
  always_comb begin
    w_nextState = r_state;
    w_cpuEn     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clrEv)                                 w_nextState = CLEAR;
        else if (bus.cpu_halted && (w_runEv || w_stepEv)) w_nextState = HALTED;
        else if (w_runEv)                            w_nextState = RUN;
        else if (w_stepEv)                           w_nextState = STEP;
      end
      RUN: begin
        if (w_clrEv)             w_nextState = CLEAR;
        else if (bus.cpu_halted) w_nextState = HALTED;
        else if (w_runEv)        w_nextState = IDLE;
        else                     w_cpuEn     = w_divWrap;
      end
      STEP: begin
        if (w_clrEv)                 w_nextState = CLEAR;
        else if (bus.cpu_halted)     w_nextState = HALTED;
        else if (bus.cpu_instr_done) w_nextState = IDLE;
        else                         w_cpuEn     = 1'b1;
      end
      HALTED: begin
        if (w_clrEv) w_nextState = CLEAR;
      end
      CLEAR: begin
        if (r_clrCnt == CLR_LAST) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Run-rate divider: restarts on entering RUN or CLEAR, free-runs while
  // RUN continues and is held everywhere else.
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      r_div <= '0;
    end else if (w_nextState == CLEAR || (r_state == IDLE && w_nextState == RUN)) begin
      r_div <= '0;
    end else if (r_state == RUN && w_nextState == RUN) begin
      r_div <= w_divWrap ? '0 : r_div + 1'b1;
    end
  end

  // Retired-instruction counter and CLEAR length counter. Entering CLEAR
  // wins over a coincident retirement.
  always_ff @(posedge CLK_12MHz or posedge RST) begin
    if (RST) begin
      r_instrCount <= '0;
      r_clrCnt     <= '0;
    end else begin
      if (w_nextState == CLEAR && r_state != CLEAR)
        r_instrCount <= '0;
      else if (bus.cpu_instr_done && (r_state == RUN || r_state == STEP))
        r_instrCount <= r_instrCount + 8'd1;
      r_clrCnt <= (r_state == CLEAR) ? r_clrCnt + 2'd1 : 2'd0;
    end
  end

  assign bus.cpu_en      = w_cpuEn;
  assign bus.cpu_rst     = (r_state == CLEAR);
  assign bus.ctrl_state  = r_state;
  assign bus.instr_count = r_instrCount;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_exec_ctrl
// Directed/randomized bench for cpu_exec_ctrl with short debounce and run
// divider. A small core model answers cpu_en with cpu_instr_done after a
// chosen number of enabled cycles; expectations come from plain arithmetic
// on the controller's documented behaviour.
// ---------------------------------------------------------------------------
module tb_cpu_exec_ctrl;

  localparam int DB_CYC  = 4;
  localparam int RUN_DIV = 3;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_HALTED = 3'd3, S_CLEAR = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails = 0;
  int   enTotal = 0;
  int   rstTotal = 0;
  int   coreM = 0;
  int   coreCnt = 0;
  int   expCount = 0;

  always #5 clk = ~clk;

  cpu_exec_ctrl_if bus();

  cpu_exec_ctrl #(
    .DEBOUNCE_CYCLES(DB_CYC), .DB_W(3), .RUN_DIV(RUN_DIV), .DIV_W(2)
  ) dut (
    .CLK_12MHz(clk), .RST(rst), .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic stepN, input logic runN, input logic clrN);
    bus.btn_step_n = stepN;
    bus.btn_run_n  = runN;
    bus.btn_clr_n  = clrN;
  endtask

  // One clock: sample at negedge, then the core model reacts to the cpu_en
  // it saw, retiring an instruction after every coreM-th enabled cycle.
  task automatic tick();
    logic enNow;
    enNow = bus.cpu_en;
    if (enNow) enTotal++;
    if (bus.cpu_rst) rstTotal++;
    @(posedge clk);
    #1;
    bus.cpu_instr_done = 1'b0;
    if (enNow && coreM != 0) begin
      coreCnt++;
      if (coreCnt == coreM) begin
        bus.cpu_instr_done = 1'b1;
        coreCnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic waitState(input logic [2:0] exp, input int budget, input string tag, output int lat);
    lat = 0;
    while (bus.ctrl_state !== exp && lat < budget) begin
      tick();
      lat++;
    end
    checkOutput(tag, bus.ctrl_state, exp);
  endtask

  task automatic doStep(input int n);
    int lat;
    coreM = n;
    coreCnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitState(S_STEP, 20, "step_enter", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    enTotal = 0;
    waitState(S_IDLE, 40, "step_exit", lat);
    checkOutput("step_en_cycles", enTotal, n);
    expCount = (expCount + 1) % 256;
    checkOutput("step_count", bus.instr_count, expCount);
    repeat (8) tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    bus.cpu_halted = 1'b0;
    bus.cpu_instr_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", bus.ctrl_state, S_IDLE);
    checkOutput("rst_en", bus.cpu_en, 0);
    checkOutput("rst_cpu_rst", bus.cpu_rst, 0);
    checkOutput("rst_count", bus.instr_count, 0);
    rst = 1'b0;
    repeat (2) tick();

    // A 2-clock glitch on run must not be accepted
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("glitch_ignored", bus.ctrl_state, S_IDLE);

    // Genuine run press: 2 sync + DB_CYC stable + 1 pulse cycle
    coreM = 4;
    coreCnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(S_RUN, 20, "run_enter", lat);
    checkOutput("run_latency", lat, 2 + DB_CYC + 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checkOutput("run_en_pattern", bus.cpu_en, (i % RUN_DIV) == RUN_DIV - 1);
      tick();
    end
    tick();
    expCount = 1;
    checkOutput("run_count", bus.instr_count, expCount);

    // Stop with a second run press
    coreM = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(S_IDLE, 20, "run_stop", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    enTotal = 0;
    repeat (8) tick();
    checkOutput("idle_no_en", enTotal, 0);
    checkOutput("idle_count_kept", bus.instr_count, expCount);

    doStep(5);

    // Halt from RUN; run/step are ignored until clr
    coreM = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(S_RUN, 20, "halt_run_enter", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat ($urandom_range(1, 5)) tick();
    bus.cpu_halted = 1'b1;
    tick();
    checkOutput("halt_enter", bus.ctrl_state, S_HALTED);
    enTotal = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (8) tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (10) tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (8) tick();
    checkOutput("halt_ignore_btns", bus.ctrl_state, S_HALTED);
    checkOutput("halt_no_en", enTotal, 0);
    rstTotal = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(S_CLEAR, 20, "halt_clr", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    expCount = 0;
    checkOutput("clear_count_zero", bus.instr_count, expCount);
    waitState(S_IDLE, 10, "clear_exit", lat);
    checkOutput("clear_rst_cycles", rstTotal, 2);

    // Halted still high in IDLE: wait, then step goes straight to HALTED
    repeat (8) tick();
    checkOutput("idle_halted_wait", bus.ctrl_state, S_IDLE);
    enTotal = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitState(S_HALTED, 20, "idle_halted_step", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("idle_halted_no_en", enTotal, 0);
    repeat (8) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(S_CLEAR, 20, "halt_clr2", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    bus.cpu_halted = 1'b0;
    waitState(S_IDLE, 10, "clear_exit2", lat);
    repeat (8) tick();

    // Counter wrap: every cpu_en retires, cpu_en every 3rd RUN cycle, so
    // after T clocks in RUN the count is floor((T-1)/3) mod 256
    coreM = 1;
    coreCnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(S_RUN, 20, "wrap_run_enter", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (768) tick();
    checkOutput("count_255", bus.instr_count, 255);
    tick();
    checkOutput("count_wrap", bus.instr_count, 0);

    // clr and run in the same cycle: clr wins
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(S_CLEAR, 20, "prio_clr_over_run", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    rstTotal = 0;
    waitState(S_IDLE, 10, "prio_clear_exit", lat);
    checkOutput("prio_rst_cycles", rstTotal, 2);
    expCount = 0;
    checkOutput("prio_count_zero", bus.instr_count, expCount);
    repeat (8) tick();

    for (int k = 0; k < 3; k++) doStep(int'($urandom_range(1, 8)));

    // Async reset in the middle of a STEP that never completes
    coreM = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitState(S_STEP, 20, "async_step_enter", lat);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (8) tick();
    checkOutput("async_step_en", bus.cpu_en, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_state", bus.ctrl_state, S_IDLE);
    checkOutput("async_en", bus.cpu_en, 0);
    checkOutput("async_count", bus.instr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
